// File: rtl/uart_rx01_if.sv
// uart_rx01_if: received-byte bus out of the 8N1/8E1 receiver.
// master drives rx_data/rx_valid/rx_frame_err; slave observes them.
interface uart_rx01_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  modport master (
    output rx_data,
    output rx_valid,
    output rx_frame_err
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input rx_frame_err
  );
endinterface

// File: rtl/uart_rx01.sv
// uart_rx01: 8N1 UART receiver, LSB first, CLKS_PER_BIT clocks/bit.
// Ports: clk, PMOD4 (async active-high reset), RS232_Rx (serial in),
//   rx (uart_rx01_if.master: rx_data, rx_valid, rx_frame_err),
//   LED1..LED5 = rx_data[0..4].
// Define UART_RX_PARITY_EN for 8E1 (even parity bit before stop).
module uart_rx01 #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic         clk,
  input  logic         PMOD4,
  input  logic         RS232_Rx,
  uart_rx01_if.master  rx,
  output logic         LED1,
  output logic         LED2,
  output logic         LED3,
  output logic         LED4,
  output logic         LED5
);

  localparam logic [15:0] HALF =
    16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL =
    16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t      state;
  logic        sync1;
  logic        rxs;
  logic [15:0] timer;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        err_q;
`ifdef UART_RX_PARITY_EN
  logic        par_bad;
`endif

  always_ff @(posedge clk or posedge PMOD4) begin
    if (PMOD4) begin
      state   <= IDLE;
      sync1   <= 1'b1;
      rxs     <= 1'b1;
      timer   <= '0;
      idx     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      sync1   <= RS232_Rx;
      rxs     <= sync1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rxs) begin
            timer <= HALF;
            state <= START;
          end
        end
        START: begin
          if (timer != 16'd0) begin
            timer <= timer - 16'd1;
          end else if (!rxs) begin
            timer <= FULL;
            idx   <= '0;
            state <= DATA;
          end else begin
            // Start bit gone by mid-bit: glitch.
            state <= IDLE;
          end
        end
        DATA: begin
          if (timer != 16'd0) begin
            timer <= timer - 16'd1;
          end else begin
            shreg <= {rxs, shreg[7:1]};
            timer <= FULL;
            idx   <= idx + 3'd1;
            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (timer != 16'd0) begin
            timer <= timer - 16'd1;
          end else begin
            // Even parity: bit equals XOR of data.
            par_bad <= rxs ^ (^shreg);
            timer   <= FULL;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (timer != 16'd0) begin
            timer <= timer - 16'd1;
          end else if (!rxs) begin
            err_q <= 1'b1;
            state <= WAIT_HIGH;
          end else begin
`ifdef UART_RX_PARITY_EN
            if (par_bad) begin
              err_q <= 1'b1;
            end else begin
              data_q  <= shreg;
              valid_q <= 1'b1;
            end
`else
            data_q  <= shreg;
            valid_q <= 1'b1;
`endif
            state <= IDLE;
          end
        end
        WAIT_HIGH: begin
          // Hold off until a break / stuck-low line releases.
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.rx_data      = data_q;
  assign rx.rx_valid     = valid_q;
  assign rx.rx_frame_err = err_q;

  assign LED1 = data_q[0];
  assign LED2 = data_q[1];
  assign LED3 = data_q[2];
  assign LED4 = data_q[3];
  assign LED5 = data_q[4];

endmodule

// File: tb/tb_uart_rx01.sv
// tb_uart_rx01: randomized scoreboard bench for uart_rx01.
// Expected strobes are queued at frame start; a monitor pops them.
module tb_uart_rx01;
  localparam int N = 104;
  localparam int H = N / 2;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  logic clk = 1'b0;
  logic PMOD4 = 1'b1;
  logic RS232_Rx = 1'b1;
  logic LED1, LED2, LED3, LED4, LED5;

  uart_rx01_if bus ();

  uart_rx01 #(.CLKS_PER_BIT(N)) dut (
    .clk      (clk),
    .PMOD4    (PMOD4),
    .RS232_Rx (RS232_Rx),
    .rx       (bus),
    .LED1     (LED1),
    .LED2     (LED2),
    .LED3     (LED3),
    .LED4     (LED4),
    .LED5     (LED5)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       q[$];
  int         strobes[$];
  int         total = 0;
  int         bad = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at cyc %0d",
               name, act, req, cyc);
    end
  endtask

  function automatic logic [4:0] leds();
    return {LED5, LED4, LED3, LED2, LED1};
  endfunction

  // Called at a negedge; leaves the line at the stop level.
  task automatic send(logic [7:0] d, bit bad_stop,
                      bit par_flip);
    exp_t e;
    bit   par_bad;
    par_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad = par_flip;
`endif
    e.at = cyc + 2 + H + NB * N + 1;
    e.err = bad_stop || par_bad;
    e.data = e.err ? last_good : d;
    if (!e.err) last_good = d;
    q.push_back(e);
    RS232_Rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RS232_Rx = d[i];
      repeat (N) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    RS232_Rx = (^d) ^ par_flip;
    repeat (N) @(negedge clk);
`endif
    RS232_Rx = !bad_stop;
    repeat (N) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!PMOD4 && (bus.rx_valid || bus.rx_frame_err)) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected strobe: v=%0b e=%0b d=%0h",
                 bus.rx_valid, bus.rx_frame_err, bus.rx_data);
      end else begin
        e = q.pop_front();
        chk("kind", {bus.rx_valid, bus.rx_frame_err},
            e.err ? 2'b01 : 2'b10);
        chk("data", bus.rx_data, e.data);
        chk("leds", leds(), e.data[4:0]);
        chk("cycle", cyc, e.at);
        strobes.push_back(cyc);
      end
    end
  end

  initial begin
    logic [7:0] d;
    int         n0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.rx_data, 8'h00);
    chk("rst_valid", bus.rx_valid, 1'b0);
    chk("rst_err", bus.rx_frame_err, 1'b0);
    chk("rst_leds", leds(), 5'h00);
    PMOD4 = 1'b0;
    repeat (5) @(negedge clk);

    send(8'h55, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    chk("led_55", leds(), 5'b10101);

    // Short low pulse must be ignored.
    RS232_Rx = 1'b0;
    repeat (20) @(negedge clk);
    RS232_Rx = 1'b1;
    repeat (100) @(negedge clk);
    send(8'h3C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // Bad stop, line held low, then released.
    send(8'hA3, 1'b1, 1'b0);
    repeat (300) @(negedge clk);
    chk("hold_data", bus.rx_data, 8'h3C);
    RS232_Rx = 1'b1;
    repeat (10) @(negedge clk);
    send(8'h81, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // Zero-gap pair.
    n0 = strobes.size();
    send(8'h00, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0);
    repeat (3 * N) @(negedge clk);
    chk("b2b_cnt", strobes.size(), n0 + 2);
    if (strobes.size() == n0 + 2)
      chk("b2b_gap", strobes[n0 + 1] - strobes[n0], 10 * N);

    // Randomized frames, some with a bad stop bit.
    for (int k = 0; k < 8; k++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        send(d, 1'b1, 1'b0);
        repeat ($urandom_range(0, 200)) @(negedge clk);
        RS232_Rx = 1'b1;
        repeat (4) @(negedge clk);
      end else begin
        send(d, 1'b0, 1'b0);
      end
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    repeat (3 * N) @(negedge clk);

    // Reset in the middle of a 0x7E frame (bit 4).
    d = 8'h7E;
    RS232_Rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RS232_Rx = d[i];
      repeat (N) @(negedge clk);
    end
    RS232_Rx = d[4];
    repeat (H) @(negedge clk);
    chk("pre_rst_q", q.size(), 0);
    PMOD4 = 1'b1;
    #1;
    chk("mid_rst_data", bus.rx_data, 8'h00);
    chk("mid_rst_valid", bus.rx_valid, 1'b0);
    chk("mid_rst_err", bus.rx_frame_err, 1'b0);
    chk("mid_rst_leds", leds(), 5'h00);
    last_good = 8'h00;
    RS232_Rx = 1'b1;
    repeat (4) @(negedge clk);
    PMOD4 = 1'b0;
    repeat (4 * N) @(negedge clk);
    send(8'h42, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    send(8'h07, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    send(8'h3C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
`endif

    for (int w = 0; w < 3000 && q.size() != 0; w++)
      @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx01.md
# uart_rx01

Asynchronous serial receiver for the icestick board: 8 data bits, no parity, 1 stop bit (8N1), LSB first. Runs from the 12 MHz board clock at 104 clocks per bit, which gives 115200 baud. It is the receive-side counterpart to the existing UART transmit and blinker logic. Each received byte is presented with a one-cycle valid strobe, and its low five bits are mirrored on the board LEDs for bring-up.

## Interface
Parameters:
- CLKS_PER_BIT, 104, clock cycles per serial bit; legal range 4..65535.

Ports:
- clk  input  1  board clock; all state on its rising edge.
- PMOD4  input  1  reset; asynchronous, active-high. Assertion immediately forces all registers to reset values; deassertion is synchronous use.
- RS232_Rx  input  1  serial line; idles high; asynchronous to clk.
- rx_data  output  8  last correctly framed byte.
- rx_valid  output  1  one-cycle strobe; rx_data updated in the same cycle.
- rx_frame_err  output  1  one-cycle strobe on a bad stop bit (or bad parity, see Configuration).
- LED1..LED5  output  1 each  rx_data[0]..rx_data[4].

## Operation
- RS232_Rx passes through a 2-flop synchronizer. Both flops reset to 1. All decisions use the second flop (rxs).
- 16-bit bit-timer counter; 3-bit bit index; 8-bit shift register; FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - When rxs == 0, load timer with CLKS_PER_BIT/2 - 1 (integer division) and go to START.
- START:
  - Timer counts down to 0, then samples rxs.
  - rxs == 0: reload timer with CLKS_PER_BIT - 1, clear bit index, go to DATA.
  - rxs == 1: treat as a glitch, return to IDLE, no strobe.
- DATA:
  - At each timer expiry, shift rxs in at bit 7 (shift right) and reload the timer.
  - After the 8th sample (index 7), go to STOP.
- STOP:
  - At timer expiry, sample rxs.
  - rxs == 1: rx_data <= shift register, rx_valid = 1, go to IDLE.
  - rxs == 0: rx_frame_err = 1, rx_data unchanged, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rxs == 1, then go to IDLE. This prevents a break or stuck-low line from producing repeated frames.
- rx_valid and rx_frame_err are never asserted together. Each is high for exactly one cycle per frame.
- LEDs follow rx_data combinationally.
- No backpressure: a consumer that misses the strobe loses the byte. rx_data is held until the next good frame.

## Timing
- Reset values: rx_data = 0x00; rx_valid = 0; rx_frame_err = 0; LED1..LED5 = 0; state = IDLE.
- Let S be the first cycle rxs reads 0 (2 clocks after the RS232_Rx falling edge). With H = CLKS_PER_BIT/2 and N = CLKS_PER_BIT:
  - Start-bit sample at S+H.
  - Data bit k (k = 0..7) sampled at S+H+N*(k+1).
  - Stop bit sampled at S+H+9N.
  - rx_valid or rx_frame_err registered high in cycle S+H+9N+1.
  - Default values: start sample at S+52, strobe at S+989.
- Back-to-back frames: a new start bit may begin any time after the stop-bit sample. IDLE is re-entered in the strobe cycle, so a zero-gap stream is received without loss.
- Glitch rejection: any low pulse that ends before S+H is ignored.
- Reset mid-frame discards the partial byte. The first falling edge after reset release starts a new frame.

## Configuration
- UART_RX_PARITY_EN defined:
  - Frame is 8E1: one even-parity bit follows bit 7 and is sampled at S+H+9N.
  - Stop bit is sampled at S+H+10N; strobe at S+H+10N+1.
  - A parity mismatch with a good stop bit gives rx_frame_err, leaves rx_data unchanged, and returns to IDLE (not WAIT_HIGH).
- UART_RX_PARITY_EN undefined: 8N1 exactly as above. No parity state or logic is present.

## Test plan
- Reset, then send 0x55 at 104 clk/bit -> exactly one rx_valid at S+989; rx_data = 0x55; LED5..LED1 = 1,0,1,0,1; rx_frame_err stays 0.
- Drive RS232_Rx low for 20 cycles, then high -> no strobe; FSM back in IDLE; a following 0x3C is received correctly.
- Send 0xA3 with the stop bit forced 0, line held low 300 cycles, then high -> rx_frame_err pulse at S+989; rx_data keeps its previous value; no further strobes until the line is high; a following 0x81 is received.
- Send 0x00 then 0xFF with zero idle gap -> two rx_valid pulses exactly 1040 cycles apart, with data 0x00 then 0xFF.
- Assert PMOD4 at bit 4 of a 0x7E frame -> all outputs 0 immediately, no strobe for the aborted frame; next frame 0x42 is received correctly.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 1 (correct) -> rx_valid at S+1093; then 0x07 with parity bit 0 -> rx_frame_err and rx_data still 0x07.
